axis_video_framer: RTL
======================

AXIS_VIDEO_FRAMER -- requirements
Module: axis_video_framer

Interface
REQ-001 SHALL have parameter P_AXIS_DATA_WIDTH, default 64: input word width; an integer multiple of P_PIXEL_WIDTH.
REQ-002 SHALL have parameter P_PIXEL_WIDTH, default 16: output pixel width (RGB565); pixels per word PPW = P_AXIS_DATA_WIDTH/P_PIXEL_WIDTH (4).
REQ-003 SHALL have parameter P_H_RES, default 640: pixels per line; a multiple of PPW.
REQ-004 SHALL have parameter P_V_RES, default 480: lines per frame.
REQ-005 SHALL have port i_axi_clk  in  1  sole clock; all logic rising-edge.
REQ-006 SHALL have port i_axi_rst  in  1  reset, synchronous, active-high.
REQ-007 SHALL have port i_sof  in  1  one-cycle pulse; the next accepted input word is pixel (0,0).
REQ-008 SHALL have port s_axis_tvalid  in  1  input word valid.
REQ-009 SHALL have port s_axis_tready  out  1  input word accept.
REQ-010 SHALL have port s_axis_tdata  in  P_AXIS_DATA_WIDTH  packed pixels; pixel 0 in LSBs.
REQ-011 SHALL have port m_axis_tvalid  out  1  pixel valid.
REQ-012 SHALL have port m_axis_tready  in  1  downstream accept.
REQ-013 SHALL have port m_axis_tdata  out  P_PIXEL_WIDTH  pixel.
REQ-014 SHALL have port m_axis_tuser  out  1  start of frame, asserted with pixel (0,0) only.
REQ-015 SHALL have port m_axis_tlast  out  1  end of line, asserted with pixel x=P_H_RES-1.
REQ-016 SHALL have port o_frame_done  out  1  one-cycle pulse after the last pixel of a frame is transferred.
REQ-017 SHALL have port o_busy  out  1  high in RUN state.
REQ-018 SHALL have port o_err_cnt  out  16  aborted-frame count (see Configuration).

Function
REQ-019 SHALL implement states IDLE and RUN; IDLE->RUN on i_sof; RUN->IDLE on handshake of pixel (P_H_RES-1, P_V_RES-1).
REQ-020 In IDLE, SHALL drive s_axis_tready=1 and discard all input words; m_axis_tvalid=0.
REQ-021 In RUN, SHALL hold one input word and an index 0..PPW-1; m_axis_tdata = word[index*P_PIXEL_WIDTH +: P_PIXEL_WIDTH].
REQ-022 SHALL set s_axis_tready = (no word held) OR (index=PPW-1 AND m_axis_tready); one pixel per cycle is sustained without bubbles.
REQ-023 Latency: an input handshake in cycle N SHALL present its pixel 0 with m_axis_tvalid=1 in cycle N+1.
REQ-024 While m_axis_tvalid=1 and m_axis_tready=0, m_axis_tdata/tuser/tlast SHALL remain stable.
REQ-025 SHALL maintain counters x (0..P_H_RES-1) and y (0..P_V_RES-1), advancing on output handshake; x wraps to 0 and y increments after tlast.
REQ-026 On handshake of the final pixel, SHALL pulse o_frame_done in the next cycle, clear the held word, and re-enter IDLE.
REQ-027 i_sof in RUN before the final pixel (abort) SHALL drop the held word, clear x/y/index, remain in RUN, and increment the error count.
REQ-028 i_sof coincident with the final-pixel handshake SHALL start the new frame in RUN without an error and still pulse o_frame_done.
REQ-029 i_sof coincident with an input handshake SHALL make that word pixels 0..PPW-1 of the new frame.

Reset
REQ-030 On i_axi_rst, SHALL enter IDLE, clear x/y/index/held word, and drive m_axis_tvalid=0, m_axis_tuser=0, m_axis_tlast=0, m_axis_tdata=0, o_frame_done=0, o_busy=0, o_err_cnt=0, and s_axis_tready=0 while reset is high.
REQ-031 Reset mid-frame SHALL discard the partial frame; output resumes only after the next i_sof.

Configuration
REQ-032 Macro AXIS_VIDEO_FRAMER_ERR_EN defined: o_err_cnt SHALL count aborts per REQ-027, saturating at 16'hFFFF.
REQ-033 Macro AXIS_VIDEO_FRAMER_ERR_EN undefined: o_err_cnt SHALL be constant 0 with no counter logic; all other behaviour is unchanged.

Verification (bench with P_H_RES=8, P_V_RES=2, PPW=4)
REQ-034 i_sof, then 4 words 0x0003_0002_0001_0000 + k*0x0004_0004_0004_0004 with m_axis_tready=1 -> 16 pixels 0x0000..0x000F on consecutive cycles; tuser on 0x0000; tlast on 0x0007 and 0x000F; o_frame_done one cycle after 0x000F.
REQ-035 Same frame with m_axis_tready toggling 1/0 each cycle -> identical pixel sequence, stable data while stalled, s_axis_tready low while a word is held mid-unpack.
REQ-036 Words sent before any i_sof -> accepted and discarded; m_axis_tvalid stays 0; o_busy=0.
REQ-037 i_sof after 6 output pixels (ERR_EN defined) -> next pixel carries tuser with the new word's pixel 0; o_err_cnt=1; same stimulus without the macro -> o_err_cnt=0.
REQ-038 i_sof on the cycle of the final-pixel handshake -> o_frame_done=1 next cycle, o_err_cnt unchanged, next frame starts with tuser.
REQ-039 i_axi_rst asserted for 1 cycle after 5 pixels -> all outputs 0; no output until i_sof; the following frame is complete and correct.

Source files
------------

// File: rtl/axis_video_framer.sv
// axis_video_framer: unpacks AXI-Stream words into a framed pixel stream (tuser = SOF, tlast = EOL)
// Ports: i_axi_clk/i_axi_rst clock and sync active-high reset; i_sof frame-start pulse;
//        s_axis_* packed-pixel word input; m_axis_* one pixel per beat with tuser/tlast;
//        o_frame_done pulse after the last pixel; o_busy high in RUN; o_err_cnt aborted frames.
// Macro AXIS_VIDEO_FRAMER_ERR_EN enables the saturating abort counter; otherwise o_err_cnt is 0.
module axis_video_framer #(
   parameter int P_AXIS_DATA_WIDTH = 64,
   parameter int P_PIXEL_WIDTH     = 16,
   parameter int P_H_RES           = 640,
   parameter int P_V_RES           = 480
) (
   input  logic                         i_axi_clk,
   input  logic                         i_axi_rst,
   input  logic                         i_sof,
   input  logic                         s_axis_tvalid,
   output logic                         s_axis_tready,
   input  logic [P_AXIS_DATA_WIDTH-1:0] s_axis_tdata,
   output logic                         m_axis_tvalid,
   input  logic                         m_axis_tready,
   output logic [P_PIXEL_WIDTH-1:0]     m_axis_tdata,
   output logic                         m_axis_tuser,
   output logic                         m_axis_tlast,
   output logic                         o_frame_done,
   output logic                         o_busy,
   output logic [15:0]                  o_err_cnt
);
   localparam int PPW = P_AXIS_DATA_WIDTH / P_PIXEL_WIDTH;
   localparam int IW  = (PPW > 1) ? $clog2(PPW) : 1;
   localparam int XW  = (P_H_RES > 1) ? $clog2(P_H_RES) : 1;
   localparam int YW  = (P_V_RES > 1) ? $clog2(P_V_RES) : 1;
   localparam logic [IW-1:0] IDX_LAST = IW'(PPW - 1);
   localparam logic [XW-1:0] X_LAST   = XW'(P_H_RES - 1);
   localparam logic [YW-1:0] Y_LAST   = YW'(P_V_RES - 1);

   typedef enum logic {S_IDLE, S_RUN} state_t;

   state_t                       state_q, state_d;
   logic                         held_q, held_d;
   logic [P_AXIS_DATA_WIDTH-1:0] word_q, word_d;
   logic [IW-1:0]                idx_q, idx_d;
   logic [XW-1:0]                x_q, x_d;
   logic [YW-1:0]                y_q, y_d;
   logic                         done_q;
   logic                         fire_m, fire_s, final_px;
   logic [P_PIXEL_WIDTH-1:0]     pix [PPW];

   for (genvar g = 0; g < PPW; g++) begin : g_pix
      assign pix[g] = word_q[g*P_PIXEL_WIDTH +: P_PIXEL_WIDTH];
   end

   // IDLE swallows words; RUN refills when empty or as the last pixel of the held word leaves.
   assign s_axis_tready = !i_axi_rst && (state_q == S_IDLE || !held_q || (idx_q == IDX_LAST && m_axis_tready));
   assign m_axis_tvalid = state_q == S_RUN && held_q;
   assign m_axis_tdata  = pix[idx_q];
   assign m_axis_tuser  = m_axis_tvalid && x_q == '0 && y_q == '0;
   assign m_axis_tlast  = m_axis_tvalid && x_q == X_LAST;
   assign o_frame_done  = done_q;
   assign o_busy        = state_q == S_RUN;
   assign fire_m        = m_axis_tvalid && m_axis_tready;
   assign fire_s        = s_axis_tvalid && s_axis_tready;
   assign final_px      = fire_m && x_q == X_LAST && y_q == Y_LAST;

   always_comb begin
      state_d = state_q;
      held_d  = held_q;
      word_d  = word_q;
      idx_d   = idx_q;
      x_d     = x_q;
      y_d     = y_q;
      // A start pulse always restarts the frame; a word accepted alongside it is pixel (0,0).
      if (i_sof) begin
         state_d = S_RUN;
         held_d  = fire_s;
         word_d  = fire_s ? s_axis_tdata : '0;
         idx_d   = '0;
         x_d     = '0;
         y_d     = '0;
      end else if (state_q == S_RUN && final_px) begin
         state_d = S_IDLE;
         held_d  = 1'b0;
         word_d  = '0;
         idx_d   = '0;
         x_d     = '0;
         y_d     = '0;
      end else if (state_q == S_RUN) begin
         if (fire_m) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
            x_d   = (x_q == X_LAST) ? '0 : x_q + 1'b1;
            y_d   = (x_q == X_LAST) ? y_q + 1'b1 : y_q;
         end
         if (!held_q || (fire_m && idx_q == IDX_LAST)) begin
            held_d = fire_s;
            word_d = fire_s ? s_axis_tdata : word_q;
         end
      end
   end

   always_ff @(posedge i_axi_clk) begin
      if (i_axi_rst) begin
         state_q <= S_IDLE;
         held_q  <= 1'b0;
         word_q  <= '0;
         idx_q   <= '0;
         x_q     <= '0;
         y_q     <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         held_q  <= held_d;
         word_q  <= word_d;
         idx_q   <= idx_d;
         x_q     <= x_d;
         y_q     <= y_d;
         done_q  <= final_px;
      end
   end

`ifdef AXIS_VIDEO_FRAMER_ERR_EN
   logic [15:0] err_q;
   logic        abort;

   // A restart that coincides with the final pixel is a clean hand-off, not an abort.
   assign abort     = state_q == S_RUN && i_sof && !final_px;
   assign o_err_cnt = err_q;

   always_ff @(posedge i_axi_clk) begin
      if (i_axi_rst) err_q <= '0;
      else if (abort && err_q != 16'hFFFF) err_q <= err_q + 1'b1;
   end
`else
   assign o_err_cnt = '0;
`endif
endmodule
